pipeline_hazard_controller: RTL and testbench
=============================================

Name: pipeline_hazard_controller

Overview:
Central stall/flush sequencer for the 5-stage pipelined MIPS datapath, sitting beside the forwarding unit in the top-level datapath. It resolves the hazards that forwarding cannot cover: load-use, taken branch/jump, and multi-cycle data-memory waits. It drives the PC and pipeline-register write-enables and flushes, and runs a wait-timeout FSM and saturating stall/flush performance counters.

Parameters:
TIMEOUT, 64, max consecutive MEM_WAIT cycles before entering ERROR; legal range 1..2^WAIT_W-1.
WAIT_W, 8, width of the wait counter.
CNT_W, 32, width of the performance counters.

Ports:
clk  in  1  rising-edge clock.
reset  in  1  reset, synchronous, active-high.
id_ex_memRead  in  1  instruction in EX is a load.
id_ex_rt  in  5  load destination register in EX.
if_id_rs  in  5  rs of instruction in ID.
if_id_rt  in  5  rt of instruction in ID.
if_id_useRt  in  1  instruction in ID reads rt as a source.
branch_taken  in  1  EX resolved a taken branch/jump this cycle.
mem_req  in  1  instruction in MEM accesses data memory.
mem_ready  in  1  data memory completes the access this cycle.
cnt_clear  in  1  synchronous clear of both performance counters.
pc_write  out  1  PC load enable.
if_id_write  out  1  IF/ID load enable.
if_id_flush  out  1  load a NOP into IF/ID.
id_ex_write  out  1  ID/EX load enable.
id_ex_flush  out  1  load a bubble (control zeros) into ID/EX.
ex_mem_write  out  1  EX/MEM load enable.
mem_wb_flush  out  1  load a bubble into MEM/WB.
mem_error  out  1  sticky: timeout occurred.
stall_cnt  out  CNT_W  cycles with pc_write=0, excluding reset and ERROR.
flush_cnt  out  CNT_W  cycles with if_id_flush=1, excluding reset.

Behaviour:
- State and counters are registered. Control outputs are combinational from the state and current inputs, so they act on the same clock edge.
- States: RUN, MEM_WAIT, ERROR. Reset gives RUN, wait_cnt=0, mem_error=0, and both counters=0.
- While reset=1: pc_write, if_id_write, id_ex_write and ex_mem_write are 0. if_id_flush, id_ex_flush and mem_wb_flush are 1.
- Hazard conditions in RUN, evaluated in the priority order below:
  - memstall = mem_req & ~mem_ready.
  - branch = branch_taken.
  - loaduse = id_ex_memRead & (id_ex_rt!=0) & ((id_ex_rt==if_id_rs) | (if_id_useRt & id_ex_rt==if_id_rt)).
- Default (no hazard): all *_write=1 and all flushes=0.
- memstall response (highest priority): pc_write, if_id_write, id_ex_write and ex_mem_write are 0; mem_wb_flush=1; other flushes are 0. Next state is MEM_WAIT with wait_cnt=1. Any branch or load-use is deferred, because frozen registers hold their inputs stable.
- branch response: pc_write=1 (PC takes the target); if_id_flush=1; id_ex_flush=1. Branch overrides a simultaneous load-use, since the dependent instruction is squashed.
- loaduse response: pc_write=0, if_id_write=0, id_ex_flush=1. This inserts exactly one bubble; the next cycle re-evaluates (normally clear, forwarding then covers it).
- MEM_WAIT:
  - If mem_ready=1: outputs are evaluated exactly as in RUN excluding memstall (branch/loaduse rules apply); next state is RUN and wait_cnt=0.
  - Else if wait_cnt==TIMEOUT: freeze outputs; next state is ERROR; mem_error is set.
  - Else: freeze outputs and increment wait_cnt.
- ERROR: freeze outputs permanently with mem_wb_flush=1. Only reset exits ERROR. mem_error stays 1.
- TIMEOUT=1 means the first cycle spent in MEM_WAIT without mem_ready moves the FSM to ERROR.
- Counters: each increments by 1 per qualifying cycle and saturates at all-ones with no wrap. cnt_clear=1 zeroes both and takes precedence over an increment in the same cycle. Counting is frozen in ERROR.
- Register 0 never triggers load-use. The ID instruction's rt matches only when if_id_useRt=1.

Test Plan:
- Load-use: id_ex_memRead=1, id_ex_rt=8, if_id_rs=8 -> one cycle of pc_write=0, if_id_write=0, id_ex_flush=1; stall_cnt=1. Repeat with id_ex_rt=0 -> no stall.
- Branch plus load-use in the same cycle: branch_taken=1 with the load-use condition true -> pc_write=1, if_id_flush=1, id_ex_flush=1; flush_cnt=1, stall_cnt=0.
- Memory wait: mem_req=1 with mem_ready low for 3 cycles, then high -> freeze for 3 cycles (ex_mem_write=0, mem_wb_flush=1), all enables 1 on the ready cycle; stall_cnt=3, state back to RUN.
- Timeout: TIMEOUT=4, mem_ready held 0 -> ERROR after 5 frozen cycles, mem_error=1 and stays 1 after mem_ready rises; reset clears it.
- Reset mid-wait: assert reset during MEM_WAIT -> next cycle state=RUN, counters=0, flushes=1 while reset is high.
- Counter saturation and clear: CNT_W=4 with 20 stall cycles -> stall_cnt=15; cnt_clear together with a stall -> 0.

Source files
------------

// File: rtl/pipeline_hazard_controller.sv
// rtl/pipeline_hazard_controller.sv - stall/flush sequencer for the 5-stage MIPS pipeline
//
// Purpose:
//   Resolves the hazards forwarding cannot cover: load-use, taken branch/jump
//   and multi-cycle data-memory waits. Drives the PC and pipeline-register
//   write enables and flushes. A wait-timeout FSM moves to a sticky ERROR
//   state when memory never answers. Two saturating performance counters
//   track stall and flush cycles.
//
// Ports:
//   clk, reset             rising-edge clock, synchronous active-high reset
//   id_ex_memRead/_rt      load in EX and its destination register
//   if_id_rs/_rt/_useRt    source registers of the instruction in ID
//   branch_taken           EX resolved a taken branch/jump this cycle
//   mem_req, mem_ready     data-memory access in MEM and its completion
//   cnt_clear              synchronous clear of both performance counters
//   pc_write ... mem_wb_flush  pipeline enables/flushes (combinational)
//   mem_error              sticky timeout flag
//   stall_cnt, flush_cnt   saturating performance counters

module pipeline_hazard_controller #(
    parameter int TIMEOUT = 64,
    parameter int WAIT_W  = 8,
    parameter int CNT_W   = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             id_ex_memRead,
    input  logic [4:0]       id_ex_rt,
    input  logic [4:0]       if_id_rs,
    input  logic [4:0]       if_id_rt,
    input  logic             if_id_useRt,
    input  logic             branch_taken,
    input  logic             mem_req,
    input  logic             mem_ready,
    input  logic             cnt_clear,
    output logic             pc_write,
    output logic             if_id_write,
    output logic             if_id_flush,
    output logic             id_ex_write,
    output logic             id_ex_flush,
    output logic             ex_mem_write,
    output logic             mem_wb_flush,
    output logic             mem_error,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_MEM_WAIT = 2'd1,
        ST_ERROR    = 2'd2
    } state_t;

    localparam logic [WAIT_W-1:0] TIMEOUT_V = WAIT_W'(TIMEOUT);
    localparam logic [CNT_W-1:0]  CNT_MAX   = {CNT_W{1'b1}};

    state_t            state_q, state_d;
    logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
    logic              mem_error_q;
    logic [CNT_W-1:0]  stall_cnt_q;
    logic [CNT_W-1:0]  flush_cnt_q;

    logic memstall;
    logic loaduse;

    // Control vector produced by the branch/load-use rules alone.
    logic hz_pc_write, hz_if_id_write, hz_if_id_flush, hz_id_ex_flush;

    assign memstall = mem_req & ~mem_ready;

    // Register 0 is hard-wired zero, so a load into it can never create a
    // dependency; rt only counts as a source when the ID instruction reads it.
    assign loaduse = id_ex_memRead && (id_ex_rt != 5'd0) &&
                     ((id_ex_rt == if_id_rs) || (if_id_useRt && (id_ex_rt == if_id_rt)));

    // Branch beats load-use: the dependent instruction is being squashed.
    always_comb begin
        hz_pc_write    = 1'b1;
        hz_if_id_write = 1'b1;
        hz_if_id_flush = 1'b0;
        hz_id_ex_flush = 1'b0;
        if (branch_taken) begin
            hz_if_id_flush = 1'b1;
            hz_id_ex_flush = 1'b1;
        end else if (loaduse) begin
            hz_pc_write    = 1'b0;
            hz_if_id_write = 1'b0;
            hz_id_ex_flush = 1'b1;
        end
    end

    always_comb begin
        state_d      = state_q;
        wait_cnt_d   = wait_cnt_q;
        pc_write     = 1'b1;
        if_id_write  = 1'b1;
        if_id_flush  = 1'b0;
        id_ex_write  = 1'b1;
        id_ex_flush  = 1'b0;
        ex_mem_write = 1'b1;
        mem_wb_flush = 1'b0;

        if (reset) begin
            pc_write     = 1'b0;
            if_id_write  = 1'b0;
            id_ex_write  = 1'b0;
            ex_mem_write = 1'b0;
            if_id_flush  = 1'b1;
            id_ex_flush  = 1'b1;
            mem_wb_flush = 1'b1;
        end else begin
            // A freeze holds PC and IF..EX/MEM while a bubble drains into
            // MEM/WB. Deferred branch/load-use stay valid because the
            // registers feeding those inputs are held.
            logic freeze;
            freeze = 1'b0;
            unique case (state_q)
                ST_RUN: begin
                    if (memstall) begin
                        freeze     = 1'b1;
                        state_d    = ST_MEM_WAIT;
                        wait_cnt_d = WAIT_W'(1);
                    end
                end
                ST_MEM_WAIT: begin
                    if (mem_ready) begin
                        state_d    = ST_RUN;
                        wait_cnt_d = '0;
                    end else if (wait_cnt_q == TIMEOUT_V) begin
                        freeze  = 1'b1;
                        state_d = ST_ERROR;
                    end else begin
                        freeze     = 1'b1;
                        wait_cnt_d = wait_cnt_q + WAIT_W'(1);
                    end
                end
                default: begin
                    freeze = 1'b1;
                end
            endcase

            if (freeze) begin
                pc_write     = 1'b0;
                if_id_write  = 1'b0;
                id_ex_write  = 1'b0;
                ex_mem_write = 1'b0;
                mem_wb_flush = 1'b1;
            end else begin
                pc_write    = hz_pc_write;
                if_id_write = hz_if_id_write;
                if_id_flush = hz_if_id_flush;
                id_ex_flush = hz_id_ex_flush;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_RUN;
            wait_cnt_q  <= '0;
            mem_error_q <= 1'b0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            if (state_d == ST_ERROR) begin
                mem_error_q <= 1'b1;
            end
            if (cnt_clear) begin
                stall_cnt_q <= '0;
                flush_cnt_q <= '0;
            end else if (state_q != ST_ERROR) begin
                if (!pc_write && (stall_cnt_q != CNT_MAX)) begin
                    stall_cnt_q <= stall_cnt_q + CNT_W'(1);
                end
                if (if_id_flush && (flush_cnt_q != CNT_MAX)) begin
                    flush_cnt_q <= flush_cnt_q + CNT_W'(1);
                end
            end
        end
    end

    assign mem_error = mem_error_q;
    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;

endmodule

// File: tb/tb_pipeline_hazard_controller.sv
// tb/tb_pipeline_hazard_controller.sv - directed self-checking bench for pipeline_hazard_controller

module tb_pipeline_hazard_controller;

    logic       clk = 1'b0;
    logic       reset;
    logic       id_ex_memRead;
    logic [4:0] id_ex_rt;
    logic [4:0] if_id_rs;
    logic [4:0] if_id_rt;
    logic       if_id_useRt;
    logic       branch_taken;
    logic       mem_req;
    logic       mem_ready;
    logic       cnt_clear;

    // u0: TIMEOUT=4, CNT_W=4 ; u1: TIMEOUT=1, CNT_W=8
    logic       pc_write0, if_id_write0, if_id_flush0, id_ex_write0, id_ex_flush0;
    logic       ex_mem_write0, mem_wb_flush0, mem_error0;
    logic [3:0] stall_cnt0, flush_cnt0;
    logic       pc_write1, if_id_write1, if_id_flush1, id_ex_write1, id_ex_flush1;
    logic       ex_mem_write1, mem_wb_flush1, mem_error1;
    logic [7:0] stall_cnt1, flush_cnt1;

    logic [6:0] ctl0;
    assign ctl0 = {pc_write0, if_id_write0, if_id_flush0, id_ex_write0,
                   id_ex_flush0, ex_mem_write0, mem_wb_flush0};

    // {pc_w, ifid_w, ifid_f, idex_w, idex_f, exmem_w, memwb_f}
    localparam logic [6:0] C_NORM   = 7'b1101010;
    localparam logic [6:0] C_RESET  = 7'b0010101;
    localparam logic [6:0] C_FREEZE = 7'b0000001;
    localparam logic [6:0] C_BRANCH = 7'b1111110;
    localparam logic [6:0] C_LOADU  = 7'b0001110;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    pipeline_hazard_controller #(.TIMEOUT(4), .WAIT_W(8), .CNT_W(4)) u0 (
        .clk(clk), .reset(reset),
        .id_ex_memRead(id_ex_memRead), .id_ex_rt(id_ex_rt),
        .if_id_rs(if_id_rs), .if_id_rt(if_id_rt), .if_id_useRt(if_id_useRt),
        .branch_taken(branch_taken), .mem_req(mem_req), .mem_ready(mem_ready),
        .cnt_clear(cnt_clear),
        .pc_write(pc_write0), .if_id_write(if_id_write0), .if_id_flush(if_id_flush0),
        .id_ex_write(id_ex_write0), .id_ex_flush(id_ex_flush0),
        .ex_mem_write(ex_mem_write0), .mem_wb_flush(mem_wb_flush0),
        .mem_error(mem_error0), .stall_cnt(stall_cnt0), .flush_cnt(flush_cnt0)
    );

    pipeline_hazard_controller #(.TIMEOUT(1), .WAIT_W(8), .CNT_W(8)) u1 (
        .clk(clk), .reset(reset),
        .id_ex_memRead(id_ex_memRead), .id_ex_rt(id_ex_rt),
        .if_id_rs(if_id_rs), .if_id_rt(if_id_rt), .if_id_useRt(if_id_useRt),
        .branch_taken(branch_taken), .mem_req(mem_req), .mem_ready(mem_ready),
        .cnt_clear(cnt_clear),
        .pc_write(pc_write1), .if_id_write(if_id_write1), .if_id_flush(if_id_flush1),
        .id_ex_write(id_ex_write1), .id_ex_flush(id_ex_flush1),
        .ex_mem_write(ex_mem_write1), .mem_wb_flush(mem_wb_flush1),
        .mem_error(mem_error1), .stall_cnt(stall_cnt1), .flush_cnt(flush_cnt1)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        id_ex_memRead = 1'b0;
        id_ex_rt      = 5'd0;
        if_id_rs      = 5'd0;
        if_id_rt      = 5'd0;
        if_id_useRt   = 1'b0;
        branch_taken  = 1'b0;
        mem_req       = 1'b0;
        mem_ready     = 1'b0;
        cnt_clear     = 1'b0;
    endtask

    task automatic do_reset();
        idle_inputs();
        reset = 1'b1;
        step();
        reset = 1'b0;
    endtask

    task automatic set_loaduse(input logic [4:0] rt);
        id_ex_memRead = 1'b1;
        id_ex_rt      = rt;
        if_id_rs      = rt;
    endtask

    task automatic test_reset();
        idle_inputs();
        reset = 1'b1;
        mem_req = 1'b1;
        branch_taken = 1'b1;
        #2;
        checks++;
        if (ctl0 !== C_RESET) begin
            errors++;
            $display("FAIL reset_ctl: got %b want %b", ctl0, C_RESET);
        end
        step();
        step();
        idle_inputs();
        reset = 1'b0;
        #2;
        checks++;
        if (ctl0 !== C_NORM) begin
            errors++;
            $display("FAIL reset_norm_ctl: got %b want %b", ctl0, C_NORM);
        end
        checks++;
        if (stall_cnt0 !== 4'd0 || flush_cnt0 !== 4'd0 || mem_error0 !== 1'b0) begin
            errors++;
            $display("FAIL reset_regs: got stall=%0d flush=%0d err=%b want 0 0 0",
                     stall_cnt0, flush_cnt0, mem_error0);
        end
    endtask

    task automatic test_load_use();
        do_reset();
        set_loaduse(5'd8);
        #2;
        checks++;
        if (ctl0 !== C_LOADU) begin
            errors++;
            $display("FAIL loaduse_ctl: got %b want %b", ctl0, C_LOADU);
        end
        step();
        idle_inputs();
        #2;
        checks++;
        if (ctl0 !== C_NORM || stall_cnt0 !== 4'd1 || flush_cnt0 !== 4'd0) begin
            errors++;
            $display("FAIL loaduse_after: got ctl=%b stall=%0d flush=%0d want %b 1 0",
                     ctl0, stall_cnt0, flush_cnt0, C_NORM);
        end
        set_loaduse(5'd0);
        #2;
        checks++;
        if (ctl0 !== C_NORM) begin
            errors++;
            $display("FAIL loaduse_r0: got %b want %b", ctl0, C_NORM);
        end
        step();
        checks++;
        if (stall_cnt0 !== 4'd1) begin
            errors++;
            $display("FAIL loaduse_r0_cnt: got %0d want 1", stall_cnt0);
        end
        // rt dependency only when the ID instruction actually reads rt
        idle_inputs();
        id_ex_memRead = 1'b1;
        id_ex_rt = 5'd9;
        if_id_rs = 5'd3;
        if_id_rt = 5'd9;
        #2;
        checks++;
        if (ctl0 !== C_NORM) begin
            errors++;
            $display("FAIL loaduse_rt_unused: got %b want %b", ctl0, C_NORM);
        end
        if_id_useRt = 1'b1;
        #2;
        checks++;
        if (ctl0 !== C_LOADU) begin
            errors++;
            $display("FAIL loaduse_rt_used: got %b want %b", ctl0, C_LOADU);
        end
        step();
        checks++;
        if (stall_cnt0 !== 4'd2) begin
            errors++;
            $display("FAIL loaduse_rt_cnt: got %0d want 2", stall_cnt0);
        end
    endtask

    task automatic test_branch_loaduse();
        do_reset();
        set_loaduse(5'd8);
        branch_taken = 1'b1;
        #2;
        checks++;
        if (ctl0 !== C_BRANCH) begin
            errors++;
            $display("FAIL branch_ctl: got %b want %b", ctl0, C_BRANCH);
        end
        step();
        idle_inputs();
        #2;
        checks++;
        if (flush_cnt0 !== 4'd1 || stall_cnt0 !== 4'd0) begin
            errors++;
            $display("FAIL branch_cnt: got flush=%0d stall=%0d want 1 0", flush_cnt0, stall_cnt0);
        end
    endtask

    task automatic test_mem_wait();
        do_reset();
        mem_req = 1'b1;
        mem_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #2;
            checks++;
            if (ctl0 !== C_FREEZE) begin
                errors++;
                $display("FAIL memwait_freeze%0d: got %b want %b", i, ctl0, C_FREEZE);
            end
            step();
            if (i == 1) begin
                checks++;
                if (mem_error1 !== 1'b1 || mem_error0 !== 1'b0) begin
                    errors++;
                    $display("FAIL timeout1_err: got u1=%b u0=%b want 1 0", mem_error1, mem_error0);
                end
            end
        end
        mem_ready = 1'b1;
        #2;
        checks++;
        if (ctl0 !== C_NORM) begin
            errors++;
            $display("FAIL memwait_ready: got %b want %b", ctl0, C_NORM);
        end
        step();
        idle_inputs();
        #2;
        checks++;
        if (ctl0 !== C_NORM || stall_cnt0 !== 4'd3 || mem_error0 !== 1'b0) begin
            errors++;
            $display("FAIL memwait_run: got ctl=%b stall=%0d err=%b want %b 3 0",
                     ctl0, stall_cnt0, mem_error0, C_NORM);
        end
        // deferred branch is honoured on the ready cycle
        mem_req = 1'b1;
        branch_taken = 1'b1;
        #2;
        checks++;
        if (ctl0 !== C_FREEZE) begin
            errors++;
            $display("FAIL memwait_br_defer: got %b want %b", ctl0, C_FREEZE);
        end
        step();
        mem_ready = 1'b1;
        #2;
        checks++;
        if (ctl0 !== C_BRANCH) begin
            errors++;
            $display("FAIL memwait_br_ready: got %b want %b", ctl0, C_BRANCH);
        end
        step();
        idle_inputs();
        checks++;
        if (stall_cnt0 !== 4'd4 || flush_cnt0 !== 4'd1) begin
            errors++;
            $display("FAIL memwait_br_cnt: got stall=%0d flush=%0d want 4 1", stall_cnt0, flush_cnt0);
        end
    endtask

    task automatic test_timeout();
        do_reset();
        mem_req = 1'b1;
        for (int i = 0; i < 5; i++) begin
            #2;
            checks++;
            if (ctl0 !== C_FREEZE || mem_error0 !== 1'b0) begin
                errors++;
                $display("FAIL timeout_pre%0d: got ctl=%b err=%b want %b 0", i, ctl0, mem_error0, C_FREEZE);
            end
            step();
        end
        checks++;
        if (mem_error0 !== 1'b1 || stall_cnt0 !== 4'd5) begin
            errors++;
            $display("FAIL timeout_err: got err=%b stall=%0d want 1 5", mem_error0, stall_cnt0);
        end
        mem_ready = 1'b1;
        #2;
        checks++;
        if (ctl0 !== C_FREEZE) begin
            errors++;
            $display("FAIL error_frozen: got %b want %b", ctl0, C_FREEZE);
        end
        step();
        step();
        checks++;
        if (mem_error0 !== 1'b1 || stall_cnt0 !== 4'd5) begin
            errors++;
            $display("FAIL error_sticky: got err=%b stall=%0d want 1 5", mem_error0, stall_cnt0);
        end
        do_reset();
        #2;
        checks++;
        if (mem_error0 !== 1'b0 || mem_error1 !== 1'b0 || ctl0 !== C_NORM) begin
            errors++;
            $display("FAIL error_reset: got err0=%b err1=%b ctl=%b want 0 0 %b",
                     mem_error0, mem_error1, ctl0, C_NORM);
        end
    endtask

    task automatic test_reset_mid_wait();
        do_reset();
        mem_req = 1'b1;
        step();
        step();
        reset = 1'b1;
        #2;
        checks++;
        if (ctl0 !== C_RESET) begin
            errors++;
            $display("FAIL midwait_reset_ctl: got %b want %b", ctl0, C_RESET);
        end
        step();
        checks++;
        if (ctl0 !== C_RESET || stall_cnt0 !== 4'd0 || flush_cnt0 !== 4'd0) begin
            errors++;
            $display("FAIL midwait_reset_regs: got ctl=%b stall=%0d flush=%0d want %b 0 0",
                     ctl0, stall_cnt0, flush_cnt0, C_RESET);
        end
        reset = 1'b0;
        mem_req = 1'b0;
        #2;
        checks++;
        if (ctl0 !== C_NORM) begin
            errors++;
            $display("FAIL midwait_run: got %b want %b", ctl0, C_NORM);
        end
    endtask

    task automatic test_saturation();
        do_reset();
        set_loaduse(5'd12);
        for (int i = 0; i < 20; i++) begin
            step();
        end
        checks++;
        if (stall_cnt0 !== 4'd15 || stall_cnt1 !== 8'd20) begin
            errors++;
            $display("FAIL sat_stall: got u0=%0d u1=%0d want 15 20", stall_cnt0, stall_cnt1);
        end
        cnt_clear = 1'b1;
        step();
        checks++;
        if (stall_cnt0 !== 4'd0 || stall_cnt1 !== 8'd0) begin
            errors++;
            $display("FAIL sat_clear: got u0=%0d u1=%0d want 0 0", stall_cnt0, stall_cnt1);
        end
        cnt_clear = 1'b0;
        step();
        checks++;
        if (stall_cnt0 !== 4'd1) begin
            errors++;
            $display("FAIL sat_restart: got %0d want 1", stall_cnt0);
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        branch_taken = 1'b1;
        #2;
        checks++;
        if (ctl0 !== C_BRANCH) begin
            errors++;
            $display("FAIL b2b_branch: got %b want %b", ctl0, C_BRANCH);
        end
        step();
        branch_taken = 1'b0;
        set_loaduse(5'd31);
        #2;
        checks++;
        if (ctl0 !== C_LOADU) begin
            errors++;
            $display("FAIL b2b_loaduse: got %b want %b", ctl0, C_LOADU);
        end
        step();
        idle_inputs();
        #2;
        checks++;
        if (ctl0 !== C_NORM || stall_cnt0 !== 4'd1 || flush_cnt0 !== 4'd1) begin
            errors++;
            $display("FAIL b2b_cnt: got ctl=%b stall=%0d flush=%0d want %b 1 1",
                     ctl0, stall_cnt0, flush_cnt0, C_NORM);
        end
    endtask

    initial begin
        idle_inputs();
        reset = 1'b1;
        test_reset();
        test_load_use();
        test_branch_loaduse();
        test_mem_wait();
        test_timeout();
        test_reset_mid_wait();
        test_saturation();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
